// File: rtl/seq_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_decoder_pkg
// Brief    : Shared state and mode encodings for seq_decoder.
// Revision : 1.0
// ============================================================================
package seq_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic c_mode_direct = 1'b0;
    localparam logic c_mode_scan   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bin2onehot.sv
`default_nettype none
// ============================================================================
// Module   : bin2onehot
// Brief    : Combinational binary-to-one-hot decoder with an enable input.
// Revision : 1.0
// ============================================================================
module bin2onehot #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      index,
    input  logic                  en,
    output logic [2**SEL_W-1:0]   onehot
);

    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_bit
        assign onehot[k] = en && (index == SEL_W'(k));
    end

endmodule
`default_nettype wire

// File: rtl/seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seq_decoder
// Brief    : One-hot output sequencer with single-pulse and rotating-walk modes.
// Revision : 1.0
// ============================================================================
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_mode,
    input  logic [DWELL_W-1:0]    in_dwell,
    input  logic                  stop,
    output logic [2**SEL_W-1:0]   out_onehot,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      out_index
);

    localparam logic [SEL_W-1:0]   c_idx_one = SEL_W'(1);
    localparam logic [DWELL_W-1:0] c_cnt_one = DWELL_W'(1);

    state_t               r_state;
    logic [SEL_W-1:0]     r_index;
    logic                 r_valid;
    logic [DWELL_W-1:0]   r_dwell;
    logic [DWELL_W-1:0]   r_cnt;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_valid;
    assign out_index = r_index;

    // Stop is checked before dwell expiry so it always wins on a shared edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_index <= '0;
            r_valid <= 1'b0;
            r_dwell <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_index <= in_sel;
                        r_valid <= 1'b1;
                        r_dwell <= in_dwell;
                        r_cnt   <= in_dwell;
                        r_state <= (in_mode == c_mode_scan) ? SCAN : HOLD;
                    end
                end
                HOLD: begin
                    if (stop || (r_cnt == '0)) begin
                        r_state <= IDLE;
                        r_index <= '0;
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_index <= '0;
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_index <= r_index + c_idx_one;
                        r_cnt   <= r_dwell;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_index <= '0;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    bin2onehot #(
        .SEL_W (SEL_W)
    ) u_dec (
        .index  (r_index),
        .en     (r_valid),
        .onehot (out_onehot)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_decoder
// Brief    : Directed self-checking bench for seq_decoder (SEL_W=3, DWELL_W=4).
// Revision : 1.0
// ============================================================================
module tb_seq_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_sel;
    logic       in_mode;
    logic [3:0] in_dwell;
    logic       stop;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic [2:0] out_index;

    int errors = 0;
    int checks = 0;

    seq_decoder #(
        .SEL_W   (3),
        .DWELL_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_mode    (in_mode),
        .in_dwell   (in_dwell),
        .stop       (stop),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_index  (out_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_mode = 1'b0; in_dwell = '0; stop = 1'b0;
        tick(); tick();
        checks++;
        if (out_onehot !== 8'h00 || out_valid !== 1'b0 || out_index !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got onehot=%b valid=%b index=%0d want 0/0/0", out_onehot, out_valid, out_index);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stop_in_idle: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_direct();
        in_valid = 1'b1; in_sel = 3'd5; in_mode = 1'b0; in_dwell = 4'd2;
        tick();
        in_valid = 1'b0; in_sel = 3'd0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_onehot !== 8'b0010_0000 || out_index !== 3'd5 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL direct_hold cyc%0d: got onehot=%b index=%0d valid=%b ready=%b want 00100000/5/1/0",
                         c, out_onehot, out_index, out_valid, in_ready);
            end
            tick();
        end
        checks++;
        if (out_onehot !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL direct_end: got onehot=%b valid=%b ready=%b want 0/0/1", out_onehot, out_valid, in_ready);
        end
    endtask

    task automatic test_scan();
        logic [2:0] exp_idx [4];
        exp_idx[0] = 3'd6; exp_idx[1] = 3'd7; exp_idx[2] = 3'd0; exp_idx[3] = 3'd1;
        in_valid = 1'b1; in_sel = 3'd6; in_mode = 1'b1; in_dwell = 4'd0;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_index !== exp_idx[c] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL scan_walk cyc%0d: got index=%0d valid=%b want %0d/1", c, out_index, out_valid, exp_idx[c]);
            end
            if (c < 3) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (out_onehot !== 8'h00 || out_valid !== 1'b0 || out_index !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL scan_stop: got onehot=%b valid=%b index=%0d ready=%b want 0/0/0/1",
                     out_onehot, out_valid, out_index, in_ready);
        end
    endtask

    task automatic test_stop_vs_expiry();
        in_valid = 1'b1; in_sel = 3'd2; in_mode = 1'b1; in_dwell = 4'd1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_index !== 3'd2 || out_onehot !== 8'b0000_0100) begin
            errors++;
            $display("FAIL expiry_pre: got index=%0d onehot=%b want 2/00000100", out_index, out_onehot);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_index !== 3'd0 || out_onehot !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL expiry_stop: got valid=%b index=%0d onehot=%b ready=%b want 0/0/0/1",
                     out_valid, out_index, out_onehot, in_ready);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_sel = 3'd1; in_mode = 1'b1; in_dwell = 4'd3;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_onehot !== 8'h00 || out_valid !== 1'b0 || out_index !== 3'd0) begin
            errors++;
            $display("FAIL async_rst: got onehot=%b valid=%b index=%0d want 0/0/0", out_onehot, out_valid, out_index);
        end
        #1 rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_onehot !== 8'h00) begin
            errors++;
            $display("FAIL async_release: got ready=%b valid=%b onehot=%b want 1/0/0", in_ready, out_valid, out_onehot);
        end
    endtask

    task automatic test_hold_ignore();
        in_valid = 1'b1; in_sel = 3'd3; in_mode = 1'b0; in_dwell = 4'd1;
        tick();
        in_sel = 3'd7;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_index !== 3'd3 || out_onehot !== 8'b0000_1000) begin
                errors++;
                $display("FAIL hold_ignore cyc%0d: got index=%0d onehot=%b want 3/00001000", c, out_index, out_onehot);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_return: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_index !== 3'd7 || out_onehot !== 8'b1000_0000) begin
                errors++;
                $display("FAIL hold_second cyc%0d: got index=%0d onehot=%b want 7/10000000", c, out_index, out_onehot);
            end
            tick();
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_once: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] one;
        logic [7:0] exp;
        one = 8'h01;
        for (int k = 0; k < 8; k++) begin
            exp = one << k;
            in_valid = 1'b1; in_sel = 3'(k); in_mode = 1'b0; in_dwell = 4'd0;
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_onehot !== exp || out_index !== 3'(k) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep k=%0d: got onehot=%b index=%0d valid=%b want %b/%0d/1",
                         k, out_onehot, out_index, out_valid, exp, k);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_onehot !== 8'h00) begin
                errors++;
                $display("FAIL sweep_end k=%0d: got valid=%b onehot=%b want 0/0", k, out_valid, out_onehot);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_stop_vs_expiry();
        test_async_reset();
        test_hold_ignore();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3, select width; output count N = 2**SEL_W.
REQ-002 SHALL have parameter DWELL_W, default 4, dwell counter width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  request present.
REQ-006 SHALL have port in_ready  out  1  block can accept request.
REQ-007 SHALL have port in_sel  in  SEL_W  start/target index.
REQ-008 SHALL have port in_mode  in  1  0 = single pulse (DIRECT), 1 = rotating walk (SCAN).
REQ-009 SHALL have port in_dwell  in  DWELL_W  cycles per position minus one.
REQ-010 SHALL have port stop  in  1  abort current operation.
REQ-011 SHALL have port out_onehot  out  N  registered one-hot decode; all-zero when inactive.
REQ-012 SHALL have port out_valid  out  1  high when out_onehot is non-zero.
REQ-013 SHALL have port out_index  out  SEL_W  binary index of the active bit; 0 when inactive.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, SCAN.
REQ-015 SHALL drive in_ready = 1 only in IDLE, combinationally from state.
REQ-016 SHALL accept on the edge where in_valid && in_ready; in_sel, in_mode, in_dwell are captured then, and later changes are ignored.
REQ-017 SHALL assert out_onehot bit in_sel on the cycle after accept (latency 1); out_onehot[k] = 1 iff out_index == k.
REQ-018 SHALL, in DIRECT (IDLE->HOLD), hold the bit for dwell+1 cycles, then clear outputs and return to IDLE on the same edge.
REQ-019 SHALL, in SCAN (IDLE->SCAN), hold each index dwell+1 cycles, then advance index by 1 modulo N (N-1 wraps to 0), with no gap cycles.
REQ-020 SHALL stay in SCAN until stop; SCAN never self-terminates.
REQ-021 SHALL, with dwell = 0, change position every cycle (SCAN) or pulse for exactly 1 cycle (DIRECT).
REQ-022 SHALL, on stop in HOLD or SCAN, clear all outputs and enter IDLE on that edge; stop in IDLE has no effect.
REQ-023 SHALL give stop priority over dwell expiry when both occur on the same edge.
REQ-024 SHALL ignore in_valid during the cycle in which stop returns the block to IDLE; in_ready rises the following cycle.
REQ-025 SHALL keep the dwell counter at DWELL_W bits, counting down from dwell to 0; it never wraps.

Reset
REQ-026 SHALL, while rst is high, force state IDLE, out_onehot = 0, out_valid = 0, out_index = 0, dwell counter = 0, independent of clk.
REQ-027 SHALL abort any operation asserted mid-HOLD/SCAN by rst, with no residual output after release.
REQ-028 SHALL assert in_ready on the first cycle after rst deasserts.

Structure
REQ-029 SHALL define the state enum (IDLE/HOLD/SCAN) and mode encoding constants in shared package seq_decoder_pkg.
REQ-030 SHALL instantiate one combinational sub-module, bin2onehot (parametrised by SEL_W), that converts out_index to out_onehot, the generalised 2-to-4 decode.
REQ-031 SHALL keep all registers in seq_decoder; bin2onehot SHALL contain no state.

Verification
REQ-032 SHALL cover DIRECT, SEL_W=3, in_sel=5, dwell=2 -> out_onehot=8'b0010_0000 for exactly 3 cycles starting 1 cycle after accept, then 0, in_ready high again.
REQ-033 SHALL cover SCAN, in_sel=6, dwell=0 -> out_index sequence 6,7,0,1,... one per cycle; stop after 4 cycles -> outputs 0 next cycle.
REQ-034 SHALL cover SCAN, dwell=1, stop on the same edge as dwell expiry -> IDLE, no advance to the next index.
REQ-035 SHALL cover async rst pulse between clock edges mid-SCAN -> outputs 0 immediately; in_ready = 1 the cycle after release.
REQ-036 SHALL cover in_valid held high during HOLD with a changed in_sel -> ignored until IDLE, then accepted once.
REQ-037 SHALL cover an exhaustive DIRECT sweep of in_sel 0..N-1, dwell=0 -> exactly one-hot bit k, out_index = k, out_valid = 1.
